// File: rtl/fp_writeback_scheduler.sv
// rtl/fp_writeback_scheduler.sv - writeback slot scheduler for the integer and FP issue pipes
//
// Grants issue to the integer and FP pipelines so that their results never
// collide on the shared writeback port. A shift-register reservation table
// tracks every in-flight op; slot 0 is the op writing back this cycle.
// Rollback of a thread squashes its younger in-flight entries.
//
// Optional feature macro: FP_SCHED_PERF_EN (integer collision stall counter).
//
// Ports:
//   clk_i                    clock
//   reset_i                  synchronous active-high reset
//   int_req_i / int_thread_idx_i   integer issue request and its thread
//   fp_req_i  / fp_thread_idx_i    FP issue request and its thread
//   int_grant_o / fp_grant_o       combinational issue grants
//   wb_rollback_en_i / wb_rollback_thread_idx_i   rollback of one thread
//   wb_slot_valid_o / wb_slot_is_fp_o / wb_slot_thread_idx_o   registered writeback slot
//   fp_pending_o             per-thread FP-in-flight flags (slot 0 excluded)
//   sched_int_stall_count_o  integer collision stall count (0 without FP_SCHED_PERF_EN)
module fp_writeback_scheduler #(
    parameter  int NUM_THREADS = 4,
    parameter  int FP_LATENCY  = 5,
    parameter  int INT_LATENCY = 1,
    localparam int TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   int_req_i,
    input  logic [TW-1:0]          int_thread_idx_i,
    input  logic                   fp_req_i,
    input  logic [TW-1:0]          fp_thread_idx_i,
    output logic                   int_grant_o,
    output logic                   fp_grant_o,
    input  logic                   wb_rollback_en_i,
    input  logic [TW-1:0]          wb_rollback_thread_idx_i,
    output logic                   wb_slot_valid_o,
    output logic                   wb_slot_is_fp_o,
    output logic [TW-1:0]          wb_slot_thread_idx_o,
    output logic [NUM_THREADS-1:0] fp_pending_o,
    output logic [31:0]            sched_int_stall_count_o
);

    typedef struct packed {
        logic          valid;
        logic          is_fp;
        logic [TW-1:0] thread;
    } entry_t;

    entry_t slot_q  [FP_LATENCY];
    entry_t slot_sq [FP_LATENCY];   // table after rollback squash
    entry_t slot_d  [FP_LATENCY];

    logic kill_int;
    logic kill_fp;
    logic int_collision;
    logic own_slot0;

    // Cycles since grant; a larger age means an older op.
    function automatic int entry_age(input entry_t e, input int idx);
        return e.is_fp ? (FP_LATENCY - idx) : (INT_LATENCY - idx);
    endfunction

    assign kill_int = wb_rollback_en_i && (wb_rollback_thread_idx_i == int_thread_idx_i);
    assign kill_fp  = wb_rollback_en_i && (wb_rollback_thread_idx_i == fp_thread_idx_i);

    // When slot 0 belongs to the rolled-back thread, only ops younger than it
    // are squashed; otherwise the rollback is older than everything in flight.
    assign own_slot0 = slot_q[0].valid && (slot_q[0].thread == wb_rollback_thread_idx_i);

    always_comb begin
        slot_sq[0] = slot_q[0];
        for (int i = 1; i < FP_LATENCY; i++) begin
            slot_sq[i] = slot_q[i];
            if (wb_rollback_en_i && slot_q[i].valid &&
                (slot_q[i].thread == wb_rollback_thread_idx_i)) begin
                if (!own_slot0 || (entry_age(slot_q[i], i) < entry_age(slot_q[0], 0))) begin
                    slot_sq[i] = '0;
                end
            end
        end
    end

    // The integer op lands in slot INT_LATENCY-1, which is fed from slot
    // INT_LATENCY of the squashed table; a squashed entry frees it at once.
    assign int_collision = slot_sq[INT_LATENCY].valid;
    assign fp_grant_o    = fp_req_i && !reset_i && !kill_fp;
    assign int_grant_o   = int_req_i && !reset_i && !kill_int && !int_collision;

    always_comb begin
        for (int i = 0; i < FP_LATENCY - 1; i++) begin
            slot_d[i] = slot_sq[i + 1];
        end
        slot_d[FP_LATENCY-1] = '0;
        if (fp_grant_o) begin
            slot_d[FP_LATENCY-1] = '{valid: 1'b1, is_fp: 1'b1, thread: fp_thread_idx_i};
        end
        if (int_grant_o) begin
            slot_d[INT_LATENCY-1] = '{valid: 1'b1, is_fp: 1'b0, thread: int_thread_idx_i};
        end
    end

    always_comb begin
        fp_pending_o = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            for (int i = 1; i < FP_LATENCY; i++) begin
                if (slot_sq[i].valid && slot_sq[i].is_fp && (slot_sq[i].thread == TW'(t))) begin
                    fp_pending_o[t] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < FP_LATENCY; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FP_LATENCY; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign wb_slot_valid_o      = slot_q[0].valid;
    assign wb_slot_is_fp_o      = slot_q[0].is_fp;
    assign wb_slot_thread_idx_o = slot_q[0].thread;

`ifdef FP_SCHED_PERF_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_count_q <= '0;
        end else if (int_req_i && !kill_int && int_collision) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign sched_int_stall_count_o = stall_count_q;
`else
    assign sched_int_stall_count_o = '0;
`endif

endmodule

// File: tb/tb_fp_writeback_scheduler.sv
// tb/tb_fp_writeback_scheduler.sv - directed self-checking bench for fp_writeback_scheduler
module tb_fp_writeback_scheduler;

    localparam int NT = 4;
    localparam int TW = 2;
`ifdef FP_SCHED_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd1;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          int_req;
    logic [TW-1:0] int_thread;
    logic          fp_req;
    logic [TW-1:0] fp_thread;
    logic          int_grant;
    logic          fp_grant;
    logic          rb_en;
    logic [TW-1:0] rb_thread;
    logic          wb_valid;
    logic          wb_is_fp;
    logic [TW-1:0] wb_thread;
    logic [NT-1:0] fp_pending;
    logic [31:0]   stall_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    fp_writeback_scheduler #(
        .NUM_THREADS (NT),
        .FP_LATENCY  (5),
        .INT_LATENCY (1)
    ) dut (
        .clk_i                    (clk),
        .reset_i                  (reset),
        .int_req_i                (int_req),
        .int_thread_idx_i         (int_thread),
        .fp_req_i                 (fp_req),
        .fp_thread_idx_i          (fp_thread),
        .int_grant_o              (int_grant),
        .fp_grant_o               (fp_grant),
        .wb_rollback_en_i         (rb_en),
        .wb_rollback_thread_idx_i (rb_thread),
        .wb_slot_valid_o          (wb_valid),
        .wb_slot_is_fp_o          (wb_is_fp),
        .wb_slot_thread_idx_o     (wb_thread),
        .fp_pending_o             (fp_pending),
        .sched_int_stall_count_o  (stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic idle();
        int_req    = 1'b0;
        int_thread = '0;
        fp_req     = 1'b0;
        fp_thread  = '0;
        rb_en      = 1'b0;
        rb_thread  = '0;
    endtask

    initial begin
        // Reset: grants forced low even with requests present
        idle();
        reset   = 1'b1;
        int_req = 1'b1;
        fp_req  = 1'b1;
        #1;
        check("rst_int_grant", int_grant, 0);
        check("rst_fp_grant", fp_grant, 0);
        step();
        step();
        reset = 1'b0;
        idle();
        cyc = 0;
        #1;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_is_fp", wb_is_fp, 0);
        check("rst_wb_thread", wb_thread, 0);
        check("rst_fp_pending", fp_pending, 0);
        check("rst_stall", stall_count, 0);

        // 1: FP only, thread 2 at cycle 10 -> writeback at 15 only
        go_to(10);
        fp_req = 1'b1; fp_thread = 2'd2;
        #1;
        check("t1_fp_grant", fp_grant, 1);
        check("t1_int_grant", int_grant, 0);
        step(); idle(); #1;
        check("t1_pending", fp_pending, 4'b0100);
        check("t1_wbv_c11", wb_valid, 0);
        for (int k = 2; k <= 6; k++) begin
            step();
            check($sformatf("t1_wbv_c%0d", 10 + k), wb_valid, (k == 5) ? 1 : 0);
            if (k == 5) begin
                check("t1_wb_is_fp", wb_is_fp, 1);
                check("t1_wb_thread", wb_thread, 2);
                check("t1_pending_wb", fp_pending, 0);
            end
        end

        // 2: collision, FP at 20, int at 24 denied, retry at 25 granted
        go_to(20);
        fp_req = 1'b1; fp_thread = 2'd0;
        #1;
        check("t2_fp_grant", fp_grant, 1);
        step(); idle();
        go_to(24);
        int_req = 1'b1; int_thread = 2'd1;
        #1;
        check("t2_int_denied", int_grant, 0);
        step(); #1;
        check("t2_int_retry", int_grant, 1);
        check("t2_wb_fp_valid", wb_valid, 1);
        check("t2_wb_fp_is_fp", wb_is_fp, 1);
        check("t2_wb_fp_thread", wb_thread, 0);
        step(); idle(); #1;
        check("t2_wb_int_valid", wb_valid, 1);
        check("t2_wb_int_is_fp", wb_is_fp, 0);
        check("t2_wb_int_thread", wb_thread, 1);
        check("t2_stall", stall_count, EXP_STALL);
        step();
        check("t2_wbv_c27", wb_valid, 0);

        // 3: dual issue at 30, int thread 0 and FP thread 1
        go_to(30);
        int_req = 1'b1; int_thread = 2'd0;
        fp_req  = 1'b1; fp_thread  = 2'd1;
        #1;
        check("t3_int_grant", int_grant, 1);
        check("t3_fp_grant", fp_grant, 1);
        step(); idle(); #1;
        check("t3_wb_int_valid", wb_valid, 1);
        check("t3_wb_int_is_fp", wb_is_fp, 0);
        check("t3_wb_int_thread", wb_thread, 0);
        check("t3_pending", fp_pending, 4'b0010);
        for (int k = 32; k <= 34; k++) begin
            step();
            check($sformatf("t3_wbv_c%0d", k), wb_valid, 0);
        end
        step();
        check("t3_wb_fp_valid", wb_valid, 1);
        check("t3_wb_fp_is_fp", wb_is_fp, 1);
        check("t3_wb_fp_thread", wb_thread, 1);

        // 4: FP thread 3 at 40 and 42, rollback thread 3 at 45
        go_to(40);
        fp_req = 1'b1; fp_thread = 2'd3;
        #1;
        check("t4_fp_grant0", fp_grant, 1);
        step(); idle();
        go_to(42);
        fp_req = 1'b1; fp_thread = 2'd3;
        #1;
        check("t4_fp_grant1", fp_grant, 1);
        step(); idle();
        go_to(44); #1;
        check("t4_pending_pre", fp_pending, 4'b1000);
        go_to(45);
        rb_en   = 1'b1; rb_thread  = 2'd3;
        fp_req  = 1'b1; fp_thread  = 2'd3;
        int_req = 1'b1; int_thread = 2'd0;
        #1;
        check("t4_fp_killed", fp_grant, 0);
        check("t4_int_other_thread", int_grant, 1);
        check("t4_pending_rb", fp_pending, 0);
        check("t4_wb_valid", wb_valid, 1);
        check("t4_wb_thread", wb_thread, 3);
        step(); idle(); #1;
        check("t4_wb_int_valid", wb_valid, 1);
        check("t4_wb_int_is_fp", wb_is_fp, 0);
        check("t4_wb_int_thread", wb_thread, 0);
        check("t4_pending_post", fp_pending, 0);
        step();
        check("t4_squashed_c47", wb_valid, 0);

        // 5: foreign rollback, FP t1 at 50, FP t2 at 51, rollback t1 at 53
        go_to(50);
        fp_req = 1'b1; fp_thread = 2'd1;
        #1;
        check("t5_fp_grant0", fp_grant, 1);
        step();
        fp_thread = 2'd2;
        #1;
        check("t5_fp_grant1", fp_grant, 1);
        step(); idle();
        go_to(53);
        rb_en = 1'b1; rb_thread = 2'd1;
        #1;
        check("t5_slot0_empty", wb_valid, 0);
        check("t5_pending_rb", fp_pending, 4'b0100);
        step(); idle();
        step();
        check("t5_squashed_c55", wb_valid, 0);
        step();
        check("t5_wb_valid", wb_valid, 1);
        check("t5_wb_is_fp", wb_is_fp, 1);
        check("t5_wb_thread", wb_thread, 2);

        // 7: squash frees the integer slot in the same cycle
        go_to(60);
        fp_req = 1'b1; fp_thread = 2'd2;
        #1;
        check("t7_fp_grant", fp_grant, 1);
        step(); idle();
        go_to(64);
        rb_en   = 1'b1; rb_thread  = 2'd2;
        int_req = 1'b1; int_thread = 2'd0;
        #1;
        check("t7_int_freed", int_grant, 1);
        check("t7_pending", fp_pending, 0);
        step(); idle(); #1;
        check("t7_wb_valid", wb_valid, 1);
        check("t7_wb_is_fp", wb_is_fp, 0);
        check("t7_wb_thread", wb_thread, 0);
        step();
        check("t7_wbv_c66", wb_valid, 0);
        check("t7_stall", stall_count, EXP_STALL);

        // 6: three FP entries in flight, reset for one cycle
        go_to(70);
        fp_req = 1'b1; fp_thread = 2'd0;
        #1;
        step();
        fp_thread = 2'd1;
        #1;
        step();
        fp_thread = 2'd2;
        #1;
        check("t6_fp_grant2", fp_grant, 1);
        step();
        idle();
        reset   = 1'b1;
        fp_req  = 1'b1; fp_thread = 2'd3;
        int_req = 1'b1;
        #1;
        check("t6_rst_fp_grant", fp_grant, 0);
        check("t6_rst_int_grant", int_grant, 0);
        step();
        reset = 1'b0;
        idle();
        #1;
        check("t6_wb_valid", wb_valid, 0);
        check("t6_pending", fp_pending, 0);
        check("t6_wb_is_fp", wb_is_fp, 0);
        check("t6_wb_thread", wb_thread, 0);
        check("t6_stall", stall_count, 0);
        for (int k = 75; k <= 80; k++) begin
            step();
            check($sformatf("t6_wbv_c%0d", k), wb_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
